// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; aligns and extends loads, builds store lanes and strobes, carries sideband to WB.
// Latency: op none or address fault -> out_valid 1 cycle after accept; memory op -> 1 req cycle + addr/data latency + 1.
// Backpressure: in_ready only in IDLE or in DONE with out_ready; dm_* held until dm_addr_ok; result held until out_ready. MEM_ADDR_EXC_EN enables misalignment faults.
module mem_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int PASS_W = 48
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [1:0]             in_size,
    input  logic                   in_sign,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_wdata,
    input  logic [PASS_W-1:0]      in_pass,
    input  logic                   flush,
    output logic                   dm_req,
    output logic                   dm_we,
    output logic [ADDR_W-1:0]      dm_addr,
    output logic [DATA_W/8-1:0]    dm_wstrb,
    output logic [DATA_W-1:0]      dm_wdata,
    input  logic                   dm_addr_ok,
    input  logic                   dm_data_ok,
    input  logic [DATA_W-1:0]      dm_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_result,
    output logic                   out_exc,
    output logic [ADDR_W-1:0]      out_badvaddr,
    output logic [PASS_W-1:0]      out_pass
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          op_q, size_q;
    logic                sign_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, result_q;
    logic [PASS_W-1:0]   pass_q;
    logic                cancel_q;

    logic [1:0]          in_size_eff;
    logic                in_mem, in_fault, accept;
    state_t              accept_nxt;
    logic [OW-1:0]       off;
    logic [DATA_W-1:0]   ld_shift, ld_mask, ld_ext;
    logic                ld_msb;
    logic [NB-1:0]       st_strb;

    // Offset bits that must be zero for a naturally aligned access of size s
    function automatic logic [OW-1:0] low_mask(input logic [1:0] s);
        logic [OW-1:0] m;
        case (s)
            2'd0:    m = '0;
            2'd1:    m = OW'(1);
            2'd2:    m = OW'(3);
            default: m = OW'(7);
        endcase
        return m;
    endfunction

    // A dword request on a 32-bit datapath degrades to a word access
    assign in_size_eff = ((DATA_W == 32) && (in_size == 2'd3)) ? 2'd2 : in_size;
    assign in_mem      = (in_op == OP_LOAD) || (in_op == OP_STORE);
    assign accept      = in_valid && in_ready;
    assign accept_nxt  = (!in_mem || in_fault) ? S_DONE : S_REQ;

`ifdef MEM_ADDR_EXC_EN
    logic              exc_q;
    logic [ADDR_W-1:0] badv_q;

    assign in_fault     = in_mem && ((in_addr[OW-1:0] & low_mask(in_size_eff)) != '0);
    assign out_exc      = exc_q;
    assign out_badvaddr = badv_q;

    // Fault flag and faulting address are captured with the operation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_q  <= 1'b0;
            badv_q <= '0;
        end else if (accept) begin
            exc_q  <= in_fault;
            badv_q <= in_fault ? in_addr : '0;
        end
    end
`else
    assign in_fault     = 1'b0;
    assign out_exc      = 1'b0;
    assign out_badvaddr = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; an accepted request is never abandoned mid-flight, it drains via cancel
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = accept_nxt;
            S_REQ: begin
                if (dm_addr_ok) state_nxt = S_WAIT;
                else if (flush) state_nxt = S_IDLE;
            end
            S_WAIT: if (dm_data_ok) state_nxt = (cancel_q || flush) ? S_IDLE : S_DONE;
            S_DONE: begin
                if (flush)          state_nxt = S_IDLE;
                else if (out_ready) state_nxt = accept ? accept_nxt : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake and request outputs decoded from state and latched op
    always_comb begin
        in_ready  = ((state == S_IDLE) || ((state == S_DONE) && out_ready)) && !flush && !cancel_q;
        dm_req    = (state == S_REQ);
        dm_we     = (state == S_REQ) && (op_q == OP_STORE);
        out_valid = (state == S_DONE);
    end

    // Operation latch, result register and cancel flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= 2'd0;
            size_q   <= 2'd0;
            sign_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            pass_q   <= '0;
            result_q <= '0;
            cancel_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= in_op;
                size_q   <= in_size_eff;
                sign_q   <= in_sign;
                addr_q   <= in_addr;
                wdata_q  <= in_wdata;
                pass_q   <= in_pass;
                result_q <= in_mem ? '0 : DATA_W'(in_addr);
            end else if ((state == S_WAIT) && dm_data_ok && (op_q == OP_LOAD) && !cancel_q && !flush) begin
                result_q <= ld_ext;
            end
            if ((state == S_WAIT) && dm_data_ok)
                cancel_q <= 1'b0;
            else if (flush && ((state == S_WAIT) || ((state == S_REQ) && dm_addr_ok)))
                cancel_q <= 1'b1;
        end
    end

    // Byte offset inside the bus word; without faults the low size bits are forced aligned
    always_comb begin
`ifdef MEM_ADDR_EXC_EN
        off = addr_q[OW-1:0];
`else
        off = addr_q[OW-1:0] & ~low_mask(size_q);
`endif
    end

    // Load alignment/extension and store strobe base
    always_comb begin
        ld_shift = dm_rdata >> {off, 3'b000};
        case (size_q)
            2'd0: begin
                ld_mask = DATA_W'(8'hFF);
                ld_msb  = ld_shift[7];
                st_strb = NB'(1);
            end
            2'd1: begin
                ld_mask = DATA_W'(16'hFFFF);
                ld_msb  = ld_shift[15];
                st_strb = NB'(3);
            end
            2'd2: begin
                ld_mask = DATA_W'(32'hFFFF_FFFF);
                ld_msb  = ld_shift[31];
                st_strb = NB'(15);
            end
            default: begin
                ld_mask = '1;
                ld_msb  = ld_shift[DATA_W-1];
                st_strb = NB'(255);
            end
        endcase
        ld_ext = (ld_shift & ld_mask) | ((sign_q && ld_msb) ? ~ld_mask : '0);
    end

    assign dm_addr    = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    assign dm_wstrb   = dm_we ? (st_strb << off) : '0;
    assign dm_wdata   = wdata_q << {off, 3'b000};
    assign out_result = result_q;
    assign out_pass   = pass_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu on a 64-bit datapath with a randomized-latency memory.
// Latency: not applicable; the bench drives and samples one cycle at a time.
// Backpressure: out_ready and memory accept/data latency are randomized outside the directed sections.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready;
    logic [1:0]  in_op, in_size;
    logic        in_sign;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic [47:0] in_pass;
    logic        flush;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [7:0]  dm_wstrb;
    logic [63:0] dm_wdata;
    logic        dm_addr_ok, dm_data_ok;
    logic [63:0] dm_rdata;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic        out_exc;
    logic [31:0] out_badvaddr;
    logic [47:0] out_pass;

    typedef struct {
        logic [63:0] res;
        logic        exc;
        logic [31:0] badv;
        logic [47:0] pass;
        bit          chk_res;
    } exp_res_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } exp_req_t;

    exp_res_t    res_q[$];
    exp_req_t    req_q[$];
    logic [7:0]  ref_mem [0:255];
    logic [7:0]  dev_mem [0:255];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          force_stall = -1;
    int          force_delay = -1;
    bit          rdy_rand = 1'b0;

    // responder / monitor state
    int          stall_left = -1;
    int          data_left  = -1;
    exp_req_t    cur_req;
    logic [63:0] rdata_nxt;
    exp_res_t    mon_e;

    mem_lsu #(.DATA_W(64), .ADDR_W(32), .PASS_W(48)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
        .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata), .in_pass(in_pass),
        .flush(flush),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_addr_ok(dm_addr_ok), .dm_data_ok(dm_data_ok), .dm_rdata(dm_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_exc(out_exc), .out_badvaddr(out_badvaddr), .out_pass(out_pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model + driver: expectation pushed first, then the operation offered until accepted.
    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [47:0] pass,
                         input bit want_out, output int waited, output logic ov);
        exp_res_t    er;
        exp_req_t    rq;
        int          n;
        int          off;
        bit          mem_op;
        bit          fault;
        logic [31:0] ea;
        logic [63:0] val;
        n      = 1 << size;
        mem_op = (op == 2'd1) || (op == 2'd2);
        fault  = 1'b0;
`ifdef MEM_ADDR_EXC_EN
        fault  = mem_op && ((addr & 32'(n - 1)) != 32'd0);
`endif
        ea      = addr & ~32'(n - 1);
        off     = int'(ea[2:0]);
        er.pass = pass;
        er.exc  = fault;
        er.badv = fault ? addr : 32'd0;
        er.chk_res = !fault;
        er.res  = 64'd0;
        if (!mem_op) begin
            er.res = {32'd0, addr};
        end else if (!fault) begin
            rq.addr  = {ea[31:3], 3'b000};
            rq.we    = (op == 2'd2);
            rq.strb  = 8'd0;
            rq.wdata = wdata << (8 * off);
            if (op == 2'd1) begin
                val = 64'd0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[ea[7:0] + 8'(i)];
                if (sign && (n < 8) && val[8*n-1])
                    for (int i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
                er.res = val;
            end else begin
                for (int i = 0; i < n; i++) begin
                    ref_mem[ea[7:0] + 8'(i)] = wdata[8*i +: 8];
                    rq.strb[off + i] = 1'b1;
                end
            end
            req_q.push_back(rq);
        end
        if (want_out) res_q.push_back(er);

        in_valid = 1'b1; in_op = op; in_size = size; in_sign = sign;
        in_addr = addr; in_wdata = wdata; in_pass = pass;
        waited = 0;
        #4;
        while (!in_ready && waited < 300) begin
            @(negedge clk); #4;
            waited++;
        end
        ov = out_valid;
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (res_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_results", 64'(res_q.size()), 64'd0);
    endtask

    task automatic rand_op(input bit want_out);
        logic [1:0]  op;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [63:0] wd;
        logic [63:0] p;
        int          w;
        logic        ov;
        op = 2'($urandom_range(0, 4));
        if (op > 2'd2) op = 2'($urandom_range(1, 2));
        sz = 2'($urandom_range(0, 3));
        a  = (op == 2'd0) ? $urandom : (32'h1000 | 32'($urandom_range(0, 255)));
        wd = {$urandom, $urandom};
        p  = {$urandom, $urandom};
        issue(op, sz, 1'($urandom_range(0, 1)), a, wd, p[47:0], want_out, w, ov);
    endtask

    // out_ready source when not under directed control
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Memory responder: checks each request against the expected one, holds it through stalls
    initial begin
        dm_addr_ok = 1'b0; dm_data_ok = 1'b0; dm_rdata = 64'd0;
        forever begin
            @(negedge clk);
            dm_addr_ok = 1'b0;
            dm_data_ok = 1'b0;
            if (!resetn) begin
                stall_left = -1;
                data_left  = -1;
            end else if (data_left == 0) begin
                dm_data_ok = 1'b1;
                dm_rdata   = rdata_nxt;
                data_left  = -1;
            end else if (data_left > 0) begin
                data_left--;
            end else if (dm_req) begin
                if (stall_left < 0) begin
                    stall_left = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
                    if (req_q.size() == 0) begin
                        check("dm_req_unexpected", 64'(dm_req), 64'd0);
                        cur_req = '{32'd0, 1'b0, 8'd0, 64'd0};
                    end else begin
                        cur_req = req_q.pop_front();
                    end
                end
                check("dm_addr", 64'(dm_addr), 64'(cur_req.addr));
                check("dm_we", 64'(dm_we), 64'(cur_req.we));
                if (cur_req.we) begin
                    check("dm_wstrb", 64'(dm_wstrb), 64'(cur_req.strb));
                    check("dm_wdata", dm_wdata, cur_req.wdata);
                end
                if (stall_left == 0) begin
                    dm_addr_ok = 1'b1;
                    stall_left = -1;
                    data_left  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 2));
                    for (int i = 0; i < 8; i++) begin
                        if (dm_we && dm_wstrb[i]) dev_mem[dm_addr[7:0] + 8'(i)] = dm_wdata[8*i +: 8];
                        rdata_nxt[8*i +: 8] = dev_mem[dm_addr[7:0] + 8'(i)];
                    end
                end else begin
                    stall_left--;
                end
            end
        end
    end

    // Result monitor: pops and compares on every WB handshake
    initial begin
        forever begin
            @(negedge clk); #4;
            if (resetn && out_valid && out_ready) begin
                if (res_q.size() == 0) begin
                    check("out_valid_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = res_q.pop_front();
                    check("out_exc", 64'(out_exc), 64'(mon_e.exc));
                    check("out_badvaddr", 64'(out_badvaddr), 64'(mon_e.badv));
                    check("out_pass", 64'(out_pass), 64'(mon_e.pass));
                    if (mon_e.chk_res) check("out_result", out_result, mon_e.res);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic       ov;
        logic [7:0] b;
        resetn = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_size = 2'd0; in_sign = 1'b0;
        in_addr = 32'd0; in_wdata = 64'd0; in_pass = 48'd0; flush = 1'b0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            ref_mem[i] = b;
            dev_mem[i] = b;
        end

        // Reset values
        repeat (2) @(negedge clk);
        #4;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dm_req", 64'(dm_req), 64'd0);
        check("rst_dm_we", 64'(dm_we), 64'd0);
        check("rst_dm_wstrb", 64'(dm_wstrb), 64'd0);
        check("rst_out_exc", 64'(out_exc), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_badvaddr", 64'(out_badvaddr), 64'd0);
        check("rst_out_pass", 64'(out_pass), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Zero-wait load: req at cycle 1, data_ok cycle 2, out_valid cycle 3
        out_ready = 1'b1; force_stall = 0; force_delay = 0;
        issue(2'd2, 2'd2, 1'b0, 32'h1000, 64'h0000_0000_8011_2233, 48'h1111, 1'b1, w, ov);
        drain();
        issue(2'd1, 2'd2, 1'b1, 32'h1000, 64'd0, 48'h2222, 1'b1, w, ov);
        #4;
        check("zw_c1_dm_req", 64'(dm_req), 64'd1);
        check("zw_c1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); #4;
        check("zw_c2_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); #4;
        check("zw_c3_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        drain();

        // Byte 0x80 at offset 3, signed and unsigned
        issue(2'd1, 2'd0, 1'b1, 32'h1003, 64'd0, 48'h3333, 1'b1, w, ov);
        issue(2'd1, 2'd0, 1'b0, 32'h1003, 64'd0, 48'h4444, 1'b1, w, ov);
        drain();

        // Half store 0xBEEF at offset 6 with 3 stall cycles, then read back
        force_stall = 3;
        issue(2'd2, 2'd1, 1'b0, 32'h1026, 64'h1234_5678_9ABC_BEEF, 48'h5555, 1'b1, w, ov);
        drain();
        force_stall = 0;
        issue(2'd1, 2'd1, 1'b0, 32'h1026, 64'd0, 48'h6666, 1'b1, w, ov);
        drain();

        // op none: out_valid one cycle after accept
        issue(2'd0, 2'd0, 1'b0, 32'hCAFE_0001, 64'd0, 48'h7777, 1'b1, w, ov);
        #4;
        check("none_out_valid_c1", 64'(out_valid), 64'd1);
        @(negedge clk);
        drain();

        // Misaligned word load at 0x1002
        issue(2'd1, 2'd2, 1'b1, 32'h1002, 64'd0, 48'h8888, 1'b1, w, ov);
        #4;
`ifdef MEM_ADDR_EXC_EN
        check("exc_out_valid_c1", 64'(out_valid), 64'd1);
        check("exc_no_dm_req", 64'(dm_req), 64'd0);
`else
        check("noexc_out_valid_c1", 64'(out_valid), 64'd0);
        check("noexc_dm_req", 64'(dm_req), 64'd1);
`endif
        @(negedge clk);
        drain();

        // Randomized traffic
        rdy_rand = 1'b1; force_stall = -1; force_delay = -1;
        for (int k = 0; k < 300; k++) begin
            rand_op(1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_rand = 1'b0; out_ready = 1'b1;
        drain();

        // Flush in WAIT: cancelled load, in_ready low until after data_ok
        force_stall = 0; force_delay = 3;
        issue(2'd1, 2'd3, 1'b0, 32'h1040, 64'd0, 48'h9999, 1'b0, w, ov);
        @(negedge clk);
        flush = 1'b1;
        begin
            int  n = 0;
            bit  seen = 1'b0;
            while (!seen && n < 20) begin
                #4;
                check("cancel_in_ready", 64'(in_ready), 64'd0);
                seen = dm_data_ok;
                @(negedge clk);
                flush = 1'b0;
                n++;
            end
            check("cancel_data_ok_seen", 64'(seen), 64'd1);
        end
        #4;
        check("cancel_in_ready_after", 64'(in_ready), 64'd1);
        @(negedge clk);
        force_delay = -1;
        issue(2'd1, 2'd2, 1'b1, 32'h1044, 64'd0, 48'hAAAA, 1'b1, w, ov);
        drain();

        // Flush in DONE drops out_valid
        out_ready = 1'b0;
        issue(2'd0, 2'd0, 1'b0, 32'h0BAD_F00D, 64'd0, 48'hBBBB, 1'b0, w, ov);
        #4;
        check("done_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        #4;
        check("done_flush_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);

        // Back-to-back op none with out_ready held high
        for (int k = 0; k < 6; k++) begin
            logic [63:0] p;
            p = {$urandom, $urandom};
            issue(2'd0, 2'd0, 1'b0, $urandom, 64'd0, p[47:0], 1'b1, w, ov);
            check("b2b_wait", 64'(w), 64'd0);
            if (k > 0) check("b2b_out_valid", 64'(ov), 64'd1);
        end
        drain();

        // Asynchronous reset while a request is stalled
        force_stall = 10;
        issue(2'd1, 2'd2, 1'b0, 32'h1080, 64'd0, 48'hCCCC, 1'b0, w, ov);
        #2;
        check("pre_rst_dm_req", 64'(dm_req), 64'd1);
        resetn = 1'b0;
        #1;
        check("async_rst_dm_req", 64'(dm_req), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #2 resetn = 1'b1;
        force_stall = -1;
        @(negedge clk); #4;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_pass", 64'(out_pass), 64'd0);
        @(negedge clk);
        for (int k = 0; k < 20; k++) rand_op(1'b1);
        drain();
        repeat (8) @(negedge clk);
        check("req_queue_empty", 64'(req_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
